// File: rtl/kf_cmu_pkg.sv
// Shared types and constants for the CMU result collection path.
package kf_cmu_pkg;

    localparam int DBL_WIDTH      = 64;
    localparam int NUM_CH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } collect_state_t;

endpackage

// File: rtl/kf_lowest_set.sv
// Combinational priority encoder: reports whether any bit is set and the index of the lowest one.
module kf_lowest_set #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/kf_cmu_result_collector.sv
// Buffers one result per CMU channel and serializes them onto a single valid/ready write port,
// tracking per-epoch completion and sticky protocol-error flags.
module kf_cmu_result_collector
    import kf_cmu_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH*DBL_WIDTH-1:0] ch_data,
    output logic                        wr_valid,
    input  logic                        wr_ready,
    output logic [IDX_W-1:0]            wr_idx,
    output logic [DBL_WIDTH-1:0]        wr_data,
    output logic                        busy,
    output logic                        done,
    output logic                        err_overflow,
    output logic                        err_dup,
    output logic                        err_early
);

    collect_state_t state_reg, state_next;

    logic [NUM_CH-1:0]    pending_reg, pending_next;
    logic [NUM_CH-1:0]    received_reg, received_next;
    logic [DBL_WIDTH-1:0] hold_mem [NUM_CH];

    logic                 slot_valid_reg;
    logic [IDX_W-1:0]     slot_idx_reg;
    logic [DBL_WIDTH-1:0] slot_data_reg;

    logic err_overflow_reg, err_overflow_next;
    logic err_dup_reg, err_dup_next;
    logic err_early_reg, err_early_next;

    logic              lo_any;
    logic [IDX_W-1:0]  lo_idx;
    logic              in_collect, accept, slot_free, load, start_ok;
    logic [NUM_CH-1:0] drain_mask, capture;

    kf_lowest_set #(
        .N  (NUM_CH),
        .IW (IDX_W)
    ) u_lowest (
        .req (pending_reg),
        .any (lo_any),
        .idx (lo_idx)
    );

    assign in_collect = (state_reg == COLLECT);
    assign accept     = slot_valid_reg & wr_ready;
    assign slot_free  = ~slot_valid_reg | accept;
    assign load       = slot_free & lo_any;
    assign drain_mask = load ? (NUM_CH'(1) << lo_idx) : '0;
    // A channel whose result is moving into the slot this cycle may accept a new one.
    assign capture    = in_collect ? (ch_valid & (~pending_reg | drain_mask)) : '0;
    assign start_ok   = start & ~in_collect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) state_next = COLLECT;
            end
            COLLECT: begin
                if (&received_reg && !(|pending_reg) && slot_free) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            COLLECT: busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pending_next      = (pending_reg & ~drain_mask) | capture;
        received_next     = start_ok ? '0 : (received_reg | capture);
        err_overflow_next = (start_ok ? 1'b0 : err_overflow_reg)
                          | (in_collect & (|(ch_valid & pending_reg & ~drain_mask)));
        err_dup_next      = (start_ok ? 1'b0 : err_dup_reg) | (|(capture & received_reg));
        err_early_next    = (start_ok ? 1'b0 : err_early_reg) | (~in_collect & (|ch_valid));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg      <= '0;
            received_reg     <= '0;
            err_overflow_reg <= 1'b0;
            err_dup_reg      <= 1'b0;
            err_early_reg    <= 1'b0;
            slot_valid_reg   <= 1'b0;
            slot_idx_reg     <= '0;
            slot_data_reg    <= '0;
        end else begin
            pending_reg      <= pending_next;
            received_reg     <= received_next;
            err_overflow_reg <= err_overflow_next;
            err_dup_reg      <= err_dup_next;
            err_early_reg    <= err_early_next;
            if (load) begin
                slot_valid_reg <= 1'b1;
                slot_idx_reg   <= lo_idx;
                slot_data_reg  <= hold_mem[lo_idx];
            end else if (accept) begin
                slot_valid_reg <= 1'b0;
            end
        end
    end

    // Holding registers need no reset: their contents are only read while pending is set.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (capture[k]) begin
                hold_mem[k] <= ch_data[k*DBL_WIDTH +: DBL_WIDTH];
            end
        end
    end

    assign wr_valid     = slot_valid_reg;
    assign wr_idx       = slot_idx_reg;
    assign wr_data      = slot_data_reg;
    assign err_overflow = err_overflow_reg;
    assign err_dup      = err_dup_reg;
    assign err_early    = err_early_reg;

endmodule

// File: tb/tb_kf_cmu_result_collector.sv
// Directed and randomized checks of the CMU result collector against a per-cycle behavioural model.
module tb_kf_cmu_result_collector;

    localparam int N  = 16;
    localparam int IW = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  ch_valid = '0;
    logic [N*DW-1:0] ch_data = '0;
    logic          wr_ready = 1'b0;
    logic          wr_valid;
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic          busy, done, err_overflow, err_dup, err_early;

    always #5 clk = ~clk;

    kf_cmu_result_collector #(.NUM_CH(N), .IDX_W(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ch_valid     (ch_valid),
        .ch_data      (ch_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .err_dup      (err_dup),
        .err_early    (err_early)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: 0=idle 1=collect 2=done; per-channel buffered result, received set, output slot.
    int          m_state;
    bit          m_pv [N];
    logic [63:0] m_pd [N];
    bit          m_rx [N];
    bit          m_sv;
    int          m_si;
    logic [63:0] m_sd;
    bit          m_eo, m_ed, m_ee;

    task automatic model_reset();
        m_state = 0;
        m_sv = 0; m_si = 0; m_sd = '0;
        m_eo = 0; m_ed = 0; m_ee = 0;
        for (int k = 0; k < N; k++) begin
            m_pv[k] = 0; m_pd[k] = '0; m_rx[k] = 0;
        end
    endtask

    task automatic model_step();
        bit acc, fre, all_rx, none_p;
        int lo, st_n;
        acc = m_sv && wr_ready;
        fre = !m_sv || acc;
        lo = -1; all_rx = 1; none_p = 1;
        for (int k = N - 1; k >= 0; k--) begin
            if (m_pv[k]) begin lo = k; none_p = 0; end
            if (!m_rx[k]) all_rx = 0;
        end
        st_n = m_state;
        if (m_state != 1 && start) begin
            st_n = 1; m_eo = 0; m_ed = 0; m_ee = 0;
            for (int k = 0; k < N; k++) m_rx[k] = 0;
        end else if (m_state == 1 && all_rx && none_p && fre) begin
            st_n = 2;
        end
        if (acc) m_sv = 0;
        if (fre && lo >= 0) begin
            m_sv = 1; m_si = lo; m_sd = m_pd[lo]; m_pv[lo] = 0;
        end
        for (int k = 0; k < N; k++) begin
            if (ch_valid[k]) begin
                if (m_state == 1) begin
                    if (!m_pv[k]) begin
                        m_pd[k] = ch_data[k*DW +: DW];
                        m_pv[k] = 1;
                        if (m_rx[k]) m_ed = 1;
                        m_rx[k] = 1;
                    end else begin
                        m_eo = 1;
                    end
                end else begin
                    m_ee = 1;
                end
            end
        end
        m_state = st_n;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [127:0] o, e;
        o = '0; e = '0;
        o[73:0] = {wr_valid, wr_valid ? wr_idx : 4'd0, wr_valid ? wr_data : 64'd0,
                   busy, done, err_overflow, err_dup, err_early};
        e[73:0] = {m_sv, m_sv ? 4'(m_si) : 4'd0, m_sv ? m_sd : 64'd0,
                   m_state == 1, m_state == 2, m_eo, m_ed, m_ee};
        check($sformatf("cycle%0d", cyc), o, e);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        cyc++;
        #1;
        check_cycle();
    endtask

    task automatic all_zero(input string tag);
        logic [127:0] o;
        o = '0;
        o[73:0] = {wr_valid, wr_idx, wr_data, busy, done, err_overflow, err_dup, err_early};
        check(tag, o, 128'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; ch_valid = '0; wr_ready = 1'b0;
        model_reset();
        #1;
        all_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic strobe(input logic [N-1:0] mask, input logic [63:0] base);
        ch_valid = mask;
        for (int k = 0; k < N; k++) ch_data[k*DW +: DW] = base + 64'(k);
        tick();
        ch_valid = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        logic [63:0] a_val, b_val;

        // Single-channel latency
        do_reset();
        wr_ready = 1'b1;
        do_start();
        check("busy_after_start", 128'(busy), 128'd1);
        strobe(16'h0008, 64'h3FF0000000000000 - 64'd3);
        check("t1_latency1_no_write", 128'(wr_valid), 128'd0);
        tick();
        check("t1_wr_valid", 128'(wr_valid), 128'd1);
        check("t1_wr_idx", 128'(wr_idx), 128'd3);
        check("t1_wr_data", 128'(wr_data), 128'h3FF0000000000000);
        check("t1_no_errors", 128'({err_overflow, err_dup, err_early}), 128'd0);

        // All channels at once, back-to-back writes in index order
        do_reset();
        wr_ready = 1'b1;
        do_start();
        strobe('1, 64'h4000000000000000);
        tick();
        for (int i = 0; i < N; i++) begin
            check($sformatf("t2_valid%0d", i), 128'(wr_valid), 128'd1);
            check($sformatf("t2_idx%0d", i), 128'(wr_idx), 128'(i));
            check($sformatf("t2_data%0d", i), 128'(wr_data), 128'(64'h4000000000000000 + 64'(i)));
            tick();
        end
        check("t2_done", 128'(done), 128'd1);
        check("t2_idle_port", 128'(wr_valid), 128'd0);

        // Overflow under back-pressure: first data kept, one write for ch 2
        do_reset();
        wr_ready = 1'b0;
        do_start();
        strobe(16'h0001, 64'hA000);
        a_val = 64'hAAAA000000000000;
        b_val = 64'hBBBB000000000000;
        strobe(16'h0004, a_val - 64'd2);
        tick();
        strobe(16'h0004, b_val - 64'd2);
        check("t3_overflow", 128'(err_overflow), 128'd1);
        check("t3_no_dup", 128'(err_dup), 128'd0);
        for (int i = 0; i < 6; i++) tick();
        check("t3_held_idx", 128'(wr_idx), 128'd0);
        wr_ready = 1'b1;
        tick();
        check("t3_ch2_idx", 128'(wr_idx), 128'd2);
        check("t3_ch2_data", 128'(wr_data), 128'(a_val));
        tick();
        check("t3_single_write", 128'(wr_valid), 128'd0);

        // Duplicate result in one epoch, still completes
        do_reset();
        wr_ready = 1'b1;
        do_start();
        strobe(16'h0020, 64'h1111000000000000 - 64'd5);
        tick();
        check("t4_first_data", 128'(wr_data), 128'h1111000000000000);
        tick();
        strobe(16'h0020, 64'h2222000000000000 - 64'd5);
        check("t4_dup", 128'(err_dup), 128'd1);
        tick();
        check("t4_second_idx", 128'(wr_idx), 128'd5);
        check("t4_second_data", 128'(wr_data), 128'h2222000000000000);
        strobe(~16'h0020, 64'h5000000000000000);
        waited = 0;
        while (!done && waited < 40) begin
            tick();
            waited++;
        end
        check("t4_done", 128'(done), 128'd1);

        // Strobe outside an epoch
        do_reset();
        strobe(16'h0001, 64'h7);
        check("t5_early", 128'(err_early), 128'd1);
        tick();
        tick();
        check("t5_no_write", 128'(wr_valid), 128'd0);
        do_start();
        check("t5_early_cleared", 128'(err_early), 128'd0);

        // Reset mid-epoch with four results buffered
        do_reset();
        wr_ready = 1'b0;
        do_start();
        strobe(16'h0292, 64'hC000);
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        all_zero("t6_midreset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t6_no_stale%0d", i), 128'({wr_valid, busy}), 128'd0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 700; i++) begin
            start = ($urandom_range(0, 29) == 0);
            wr_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                ch_valid[k] = ($urandom_range(0, 11) == 0);
                ch_data[k*DW +: DW] = {$urandom, $urandom};
            end
            tick();
        end
        start = 1'b0;
        ch_valid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
